dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port DMEM: the pipeline MEM stage (core) and a DMA/debug port.
// Core normally wins; a starvation counter hands DMA exactly one forced grant after STARVE_LIMIT denials.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PRIO_CORE | core wins on conflict; DMA denials are counted
// PRIO_DMA  | DMA wins on conflict; left after one DMA grant or DMA idle

module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int WORD_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [WORD_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [WORD_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [WORD_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [WORD_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [WORD_WIDTH-1:0] mem_wr_word,
    output logic                  mem_write_en,
    input  logic [WORD_WIDTH-1:0] mem_rd_word
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        PRIO_CORE = 1'b0,
        PRIO_DMA  = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;

    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (state == PRIO_DMA) begin
            dma_gnt  = dma_req;
            core_gnt = core_req && !dma_req;
        end else begin
            core_gnt = core_req;
            dma_gnt  = dma_req && !core_req;
        end
    end

    assign core_stall = core_req && !core_gnt;

    always_comb begin
        starve_nxt = '0;
        if (dma_req && !dma_gnt)
            starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end

    // Both DMEM addresses follow the winner; idle cycles drive zeros.
    always_comb begin
        mem_rd_addr  = '0;
        mem_wr_addr  = '0;
        mem_wr_word  = '0;
        mem_write_en = 1'b0;
        if (core_gnt) begin
            mem_rd_addr  = core_addr;
            mem_wr_addr  = core_addr;
            mem_wr_word  = core_wdata;
            mem_write_en = core_we;
        end else if (dma_gnt) begin
            mem_rd_addr  = dma_addr;
            mem_wr_addr  = dma_addr;
            mem_wr_word  = dma_wdata;
            mem_write_en = dma_we;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= PRIO_CORE;
            starve_cnt  <= '0;
            core_rvalid <= 1'b0;
            dma_rvalid  <= 1'b0;
        end else begin
            starve_cnt  <= starve_nxt;
            core_rvalid <= core_gnt && !core_we;
            dma_rvalid  <= dma_gnt && !dma_we;
            case (state)
                PRIO_CORE: if (starve_nxt == LIMIT) state <= PRIO_DMA;
                PRIO_DMA:  if (dma_gnt || !dma_req) state <= PRIO_CORE;
                default:   state <= PRIO_CORE;
            endcase
        end
    end

    // DMEM returns the word one cycle after its address, which lines up with rvalid.
    assign core_rdata = core_rvalid ? mem_rd_word : '0;
    assign dma_rdata  = dma_rvalid  ? mem_rd_word : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reference grant model, shadow memory and
// per-requester read-data queues filled at grant time and drained on rvalid.

module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int WW = 16;
    localparam int SL = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [WW-1:0] core_wdata = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [WW-1:0] dma_wdata = '0;
    logic          core_gnt, core_rvalid, core_stall, dma_gnt, dma_rvalid, mem_write_en;
    logic [WW-1:0] core_rdata, dma_rdata, mem_wr_word;
    logic [WW-1:0] mem_rd_word = '0;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_word(mem_wr_word),
        .mem_write_en(mem_write_en), .mem_rd_word(mem_rd_word)
    );

    // DMEM model: write-first, one-cycle read latency
    logic [WW-1:0] mem_arr [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_write_en) mem_arr[mem_wr_addr] <= mem_wr_word;
        mem_rd_word <= (mem_write_en && mem_wr_addr == mem_rd_addr) ? mem_wr_word : mem_arr[mem_rd_addr];
    end

    logic [WW-1:0] shadow [0:(1<<AW)-1];
    logic [WW-1:0] core_q[$], dma_q[$];
    int  n_checks = 0, n_fail = 0;
    bit  ref_dprio = 0;
    int  ref_cnt = 0;
    bit  exp_crv = 0, exp_drv = 0;
    bit  last_egc = 0, last_egd = 0;
    logic          obs_dgnt, obs_stall, obs_crv;
    logic [WW-1:0] obs_crdata, obs_drdata;
    logic          obs_drv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [WW-1:0] cd,
                          input logic dr, input logic dw, input logic [AW-1:0] da, input logic [WW-1:0] dd);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req  = dr; dma_we  = dw; dma_addr  = da; dma_wdata  = dd;
    endtask

    task automatic idle_in();
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // One clock: check outputs at the falling edge, then advance the reference model.
    task automatic cycle();
        logic egc, egd, ewe;
        logic [AW-1:0] ea;
        logic [WW-1:0] ew, v;
        @(negedge clock);
        egc = ref_dprio ? (core_req && !dma_req) : core_req;
        egd = ref_dprio ? dma_req : (dma_req && !core_req);
        ewe = egc ? core_we    : egd ? dma_we    : 1'b0;
        ea  = egc ? core_addr  : egd ? dma_addr  : '0;
        ew  = egc ? core_wdata : egd ? dma_wdata : '0;
        obs_dgnt = dma_gnt; obs_stall = core_stall;
        obs_crv = core_rvalid; obs_crdata = core_rdata;
        obs_drv = dma_rvalid;  obs_drdata = dma_rdata;
        check_val("core_gnt", core_gnt, egc);
        check_val("dma_gnt", dma_gnt, egd);
        check_val("core_stall", core_stall, core_req && !egc);
        check_val("mem_write_en", mem_write_en, ewe);
        check_val("mem_rd_addr", mem_rd_addr, ea);
        check_val("mem_wr_addr", mem_wr_addr, ea);
        check_val("mem_wr_word", mem_wr_word, ew);
        check_val("core_rvalid", core_rvalid, exp_crv);
        check_val("dma_rvalid", dma_rvalid, exp_drv);
        if (exp_crv) begin
            if (core_q.size() == 0) check_val("core_q_empty", 1, 0);
            else begin v = core_q.pop_front(); check_val("core_rdata", core_rdata, v); end
        end else check_val("core_rdata_idle", core_rdata, 0);
        if (exp_drv) begin
            if (dma_q.size() == 0) check_val("dma_q_empty", 1, 0);
            else begin v = dma_q.pop_front(); check_val("dma_rdata", dma_rdata, v); end
        end else check_val("dma_rdata_idle", dma_rdata, 0);
        exp_crv = egc && !core_we;
        exp_drv = egd && !dma_we;
        if (egc) begin
            if (core_we) shadow[core_addr] = core_wdata; else core_q.push_back(shadow[core_addr]);
        end
        if (egd) begin
            if (dma_we) shadow[dma_addr] = dma_wdata; else dma_q.push_back(shadow[dma_addr]);
        end
        if (dma_req && !egd) ref_cnt = (ref_cnt == SL) ? SL : ref_cnt + 1;
        else ref_cnt = 0;
        if (!ref_dprio) begin
            if (ref_cnt == SL) ref_dprio = 1;
        end else if (egd || !dma_req) ref_dprio = 0;
        last_egc = egc; last_egd = egd;
        @(posedge clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cr, cw, dr, dw;
        logic [AW-1:0] ca, da;
        logic [WW-1:0] cd, dd;
        for (int i = 0; i < (1<<AW); i++) begin mem_arr[i] = '0; shadow[i] = '0; end

        // Reset state
        idle_in();
        @(negedge clock);
        check_val("rst_core_rvalid", core_rvalid, 0);
        check_val("rst_dma_rvalid", dma_rvalid, 0);
        check_val("rst_core_rdata", core_rdata, 0);
        check_val("rst_mem_write_en", mem_write_en, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Core write then read same address; first grant in first cycle out of reset
        set_in(1, 1, 12'h010, 16'hBEEF, 0, 0, '0, '0); cycle();
        set_in(1, 0, 12'h010, 16'h0000, 0, 0, '0, '0); cycle();
        idle_in(); cycle();
        check_val("raw_core_rvalid", obs_crv, 1);
        check_val("raw_core_rdata", obs_crdata, 16'hBEEF);

        // DMA alone: write then read 0x7FF
        set_in(0, 0, '0, '0, 1, 1, 12'h7FF, 16'h1234); cycle();
        set_in(0, 0, '0, '0, 1, 0, 12'h7FF, 16'h0000); cycle();
        idle_in(); cycle();
        check_val("dma_rvalid_7ff", obs_drv, 1);
        check_val("dma_rdata_7ff", obs_drdata, 16'h1234);
        check_val("core_rvalid_quiet", obs_crv, 0);
        cycle();

        // Both held high: core wins 4, DMA on the 5th, repeating
        set_in(1, 1, 12'h003, 16'h0033, 1, 1, 12'h004, 16'h0044); cycle(); idle_in(); cycle();
        set_in(1, 0, 12'h003, 16'h0000, 1, 0, 12'h004, 16'h0000);
        for (int k = 0; k < 15; k++) begin
            cycle();
            check_val("starve_dma_gnt", obs_dgnt, (k % 5) == 4);
            check_val("starve_core_stall", obs_stall, (k % 5) == 4);
        end
        idle_in(); cycle(); cycle();

        // Alternating core/DMA reads with distinct data
        set_in(1, 1, 12'h001, 16'hA001, 0, 0, '0, '0); cycle();
        set_in(0, 0, '0, '0, 1, 1, 12'h002, 16'hD002); cycle();
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) set_in(1, 0, 12'h001, '0, 0, 0, '0, '0);
            else            set_in(0, 0, '0, '0, 1, 0, 12'h002, '0);
            cycle();
            if (k > 0) begin
                check_val("alt_rvalid_owner", {obs_crv, obs_drv}, (k % 2 == 1) ? 2'b10 : 2'b01);
                check_val("alt_rdata", obs_crv ? obs_crdata : obs_drdata, (k % 2 == 1) ? 16'hA001 : 16'hD002);
            end
        end
        idle_in(); cycle(); cycle();

        // Random traffic; a stalled requester holds its request
        cr = 0; cw = 0; ca = '0; cd = '0; dr = 0; dw = 0; da = '0; dd = '0;
        for (int k = 0; k < 400; k++) begin
            if (!(cr && !last_egc)) begin
                cr = ($urandom_range(0, 3) != 0); cw = $urandom_range(0, 1);
                ca = AW'($urandom_range(0, 15)); cd = WW'($urandom);
            end
            if (!(dr && !last_egd)) begin
                dr = ($urandom_range(0, 2) != 0); dw = $urandom_range(0, 1);
                da = AW'($urandom_range(0, 15)); dd = WW'($urandom);
            end
            set_in(cr, cw, ca, cd, dr, dw, da, dd);
            cycle();
        end
        idle_in(); cycle(); cycle();

        // Reset right after a granted core read, with the starvation counter part-way up
        set_in(1, 0, 12'h003, '0, 1, 0, 12'h004, '0);
        cycle(); cycle(); cycle();
        idle_in();
        reset = 1'b0;
        #1;
        check_val("rst_mid_core_rvalid", core_rvalid, 0);
        check_val("rst_mid_core_rdata", core_rdata, 0);
        core_q.delete(); dma_q.delete();
        exp_crv = 0; exp_drv = 0; ref_dprio = 0; ref_cnt = 0;
        @(negedge clock);
        check_val("rst_hold_core_rvalid", core_rvalid, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        set_in(1, 0, 12'h003, '0, 1, 0, 12'h004, '0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_val("post_rst_dma_gnt", obs_dgnt, k == 4);
        end
        idle_in(); cycle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
